sel_scan_sequencer: RTL and testbench
=====================================

// Module: sel_scan_sequencer
// PURPOSE
//  Upstream select generator for the 3-to-8 one-hot decoder. Produces the 3-bit select code the decoder consumes.
//  Auto-scans channels 0..7 with a programmable dwell, accepts one-shot channel loads over a valid/ready handshake,
//  and flags each step and each wrap to channel 0. Turns the decoder output into a timed channel-enable scan.
// PARAMETERS
//  SEL_W    3  select width; channel count NUM_CH = 2**SEL_W
//  DWELL_W  8  dwell-count width (cycles per channel)
// PORTS
//  clk        in   1        single clock, all state on posedge
//  rst        in   1        synchronous, active-high reset
//  start      in   1        level/pulse: begin scanning from IDLE
//  stop       in   1        abort scan/hold, return to IDLE
//  dwell      in   DWELL_W  cycles per channel; 0 treated as 1; sampled at every counter reload
//  ld_valid   in   1        load request
//  ld_sel     in   SEL_W    channel to load
//  ld_ready   out  1        load can be accepted (comb.)
//  sel        out  SEL_W    select code to decoder (registered)
//  sel_valid  out  1        sel is being actively driven (SCAN or HOLD)
//  step       out  1        1-cycle pulse: sel changed this cycle
//  wrap       out  1        1-cycle pulse: scan advance passed through channel 0
//  busy       out  1        state != IDLE
//  skip_mask  in   NUM_CH   [SEQ_SKIP_MASK_EN only] bit i=1 -> channel i skipped by auto-scan
// BEHAVIOUR
//  Reset (next edge with rst=1, any state): state=IDLE, sel=0, sel_valid=0, step=0, wrap=0, busy=0, cnt=0, resume=0.
//  States: IDLE, SCAN, HOLD. Priority per cycle: rst > stop > load > start > dwell expiry.
//  IDLE: sel held. start -> SCAN, sel=0, cnt=max(dwell,1); sel_valid=1 from next cycle. step asserted only if sel changed.
//  SCAN: cnt decrements each cycle; at cnt==1: sel=next channel (wraps NUM_CH-1 -> 0), cnt reloaded, step=1;
//        wrap=1 when new sel <= old sel. Hence each channel is driven exactly max(dwell,1) cycles; dwell=0/1 -> advance every cycle.
//  Load: ld_ready = (state!=HOLD) && !stop. On ld_valid&&ld_ready: sel=ld_sel, cnt=max(dwell,1), state=HOLD,
//        resume=(state==SCAN); step=1 if sel changed; wrap=0. Load ignores skip_mask.
//  HOLD: cnt decrements; at cnt==1: resume ? SCAN with sel=next channel, step=1, wrap per SCAN rule : IDLE with sel held.
//  stop in SCAN/HOLD -> IDLE next cycle, sel retained, sel_valid=0, pending dwell discarded; stop in IDLE no effect.
//  start while SCAN/HOLD ignored. step/wrap never asserted in IDLE or on reset.
//  Latency: start at cycle N -> sel=0, sel_valid=1 at N+1; first advance visible at N+1+max(dwell,1).
// CONFIGURATION
//  SEQ_SKIP_MASK_EN defined: skip_mask port exists; auto-advance picks next channel after sel (modulo NUM_CH) with mask bit 0;
//   if every other channel masked, sel holds, step=0, wrap=0, cnt reloads. wrap=1 when search passes through index 0.
//   Current channel's own mask bit is not checked (no forced exit).
//  Not defined: no skip_mask port; next channel = sel+1 mod NUM_CH.
// STRUCTURE
//  Package sel_seq_pkg: SEL_W/NUM_CH localparams, typedef enum logic [1:0] {IDLE,SCAN,HOLD} seq_state_e, sel_t typedef.
//  One sub-module: sel_next_finder (combinational: sel, mask -> next sel, wrap, found); mask tied 0 without macro.
// TESTING
//  1 rst, dwell=2, start pulse -> sel 0 at N+1, 1 at N+3, ... 7 at N+15, 0 with wrap=1 at N+17; step every 2 cycles.
//  2 dwell=0 in SCAN -> sel advances every cycle, step continuously high, wrap every 8 cycles.
//  3 SCAN dwell=3, sel=2, ld_valid ld_sel=5 -> sel=5 next cycle, ld_ready=0 3 cycles, then sel=6 step=1, scan continues.
//  4 stop and ld_valid same cycle in SCAN -> ld_ready=0, load not taken, IDLE, busy=0, sel unchanged.
//  5 rst asserted mid-HOLD -> next edge sel=0, sel_valid=0, busy=0, ld_ready=1; no step/wrap pulse.
//  6 SEQ_SKIP_MASK_EN, mask=8'b0110_1010, dwell=1 -> sel 0,2,4,7,0 (wrap=1 on 7->0); mask=8'hFE at sel=0 -> sel holds, step=0.

Source files
------------

// File: rtl/sel_seq_pkg.sv
// Shared types and constants for the select scan sequencer.
package sel_seq_pkg;

    localparam int SEL_W  = 3;
    localparam int NUM_CH = 2 ** SEL_W;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } seq_state_e;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/sel_scan_sequencer_next_finder.sv
// Combinational search for the next unmasked channel after the current one.
// found=0 when every other channel is masked; wrap=1 when the search passed index 0.
module sel_next_finder #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic [2**SEL_W-1:0]   mask,
    output logic [SEL_W-1:0]      next_sel,
    output logic                  wrap,
    output logic                  found
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest unmasked channel wins.
    always_comb begin
        next_sel = sel;
        found    = 1'b0;
        cand     = sel;
        for (int unsigned i = 2 ** SEL_W - 1; i >= 1; i--) begin
            cand = sel + SEL_W'(i);
            if (!mask[cand]) begin
                next_sel = cand;
                found    = 1'b1;
            end
        end
        wrap = found && (next_sel < sel);
    end

endmodule

// File: rtl/sel_scan_sequencer.sv
// Select-code scan sequencer feeding a one-hot decoder.
// Optional feature: define SEQ_SKIP_MASK_EN to add the skip_mask port.
module sel_scan_sequencer
    import sel_seq_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               ld_valid,
    input  logic [SEL_W-1:0]   ld_sel,
    output logic               ld_ready,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               step,
    output logic               wrap,
    output logic               busy
`ifdef SEQ_SKIP_MASK_EN
    ,
    input  logic [2**SEL_W-1:0] skip_mask
`endif
);

    seq_state_e         state, state_n;
    logic [SEL_W-1:0]   sel_n;
    logic [DWELL_W-1:0] cnt, cnt_n, reload;
    logic               resume, resume_n;
    logic               step_n, wrap_n;

    logic [2**SEL_W-1:0] mask;
    logic [SEL_W-1:0]    adv_sel;
    logic                adv_wrap, adv_found;

`ifdef SEQ_SKIP_MASK_EN
    assign mask = skip_mask;
`else
    assign mask = '0;
`endif

    sel_next_finder #(.SEL_W(SEL_W)) u_finder (
        .sel      (sel),
        .mask     (mask),
        .next_sel (adv_sel),
        .wrap     (adv_wrap),
        .found    (adv_found)
    );

    assign reload    = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign ld_ready  = (state != HOLD) && !stop;
    assign busy      = (state != IDLE);
    assign sel_valid = (state != IDLE);

    // Next-state decode in priority order: stop > load > start > dwell expiry.
    always_comb begin
        state_n  = state;
        sel_n    = sel;
        cnt_n    = cnt;
        resume_n = resume;
        step_n   = 1'b0;
        wrap_n   = 1'b0;
        if (stop && state != IDLE) begin
            state_n  = IDLE;
            cnt_n    = '0;
            resume_n = 1'b0;
        end else if (ld_valid && ld_ready) begin
            state_n  = HOLD;
            sel_n    = ld_sel;
            cnt_n    = reload;
            resume_n = (state == SCAN);
            step_n   = (ld_sel != sel);
        end else if (start && state == IDLE) begin
            state_n = SCAN;
            sel_n   = '0;
            cnt_n   = reload;
            step_n  = (sel != '0);
        end else if (state != IDLE) begin
            if (cnt > DWELL_W'(1)) begin
                cnt_n = cnt - DWELL_W'(1);
            end else if (state == SCAN || resume) begin
                // Expiry in SCAN, or end of a load taken mid-scan: advance and keep scanning.
                state_n  = SCAN;
                resume_n = 1'b0;
                cnt_n    = reload;
                if (adv_found) begin
                    sel_n  = adv_sel;
                    step_n = 1'b1;
                    wrap_n = adv_wrap;
                end
            end else begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sel    <= '0;
            cnt    <= '0;
            resume <= 1'b0;
            step   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            state  <= state_n;
            sel    <= sel_n;
            cnt    <= cnt_n;
            resume <= resume_n;
            step   <= step_n;
            wrap   <= wrap_n;
        end
    end

endmodule

// File: tb/tb_sel_scan_sequencer.sv
// Randomized and directed bench for sel_scan_sequencer against a behavioural model.
module tb_sel_scan_sequencer;

    localparam int SW  = 3;
    localparam int NCH = 8;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          rst, start, stop, ld_valid;
    logic [DW-1:0] dwell;
    logic [SW-1:0] ld_sel;
    logic          ld_ready, sel_valid, step, wrap, busy;
    logic [SW-1:0] sel;
`ifdef SEQ_SKIP_MASK_EN
    logic [NCH-1:0] skip_mask;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mode 0=idle 1=scanning 2=holding a loaded channel
    int m_mode, m_sel, m_left, m_resume, m_step, m_wrap;

    always #5 clk = ~clk;

    sel_scan_sequencer #(.SEL_W(SW), .DWELL_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .dwell     (dwell),
        .ld_valid  (ld_valid),
        .ld_sel    (ld_sel),
        .ld_ready  (ld_ready),
        .sel       (sel),
        .sel_valid (sel_valid),
        .step      (step),
        .wrap      (wrap),
        .busy      (busy)
`ifdef SEQ_SKIP_MASK_EN
        ,
        .skip_mask (skip_mask)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit skipped(input int ch);
`ifdef SEQ_SKIP_MASK_EN
        return skip_mask[ch];
`else
        return 1'b0;
`endif
    endfunction

    function automatic int dwell_cycles();
        return (dwell == 0) ? 1 : int'(dwell);
    endfunction

    // Move to the nearest unskipped channel ahead; stay put if none exists.
    task automatic model_advance();
        m_left = dwell_cycles();
        for (int k = 1; k < NCH; k++) begin
            if (!skipped((m_sel + k) % NCH)) begin
                m_wrap = (m_sel + k >= NCH);
                m_sel  = (m_sel + k) % NCH;
                m_step = 1;
                return;
            end
        end
    endtask

    task automatic model_tick();
        m_step = 0;
        m_wrap = 0;
        if (rst) begin
            m_mode = 0; m_sel = 0; m_left = 0; m_resume = 0;
        end else if (stop && m_mode != 0) begin
            m_mode = 0; m_left = 0; m_resume = 0;
        end else if (ld_valid && m_mode != 2 && !stop) begin
            m_step   = (int'(ld_sel) != m_sel);
            m_sel    = int'(ld_sel);
            m_left   = dwell_cycles();
            m_resume = (m_mode == 1);
            m_mode   = 2;
        end else if (start && m_mode == 0) begin
            m_step = (m_sel != 0);
            m_sel  = 0;
            m_left = dwell_cycles();
            m_mode = 1;
        end else if (m_mode != 0) begin
            if (m_left > 1) m_left--;
            else if (m_mode == 1 || m_resume == 1) begin
                m_mode = 1; m_resume = 0;
                model_advance();
            end else m_mode = 0;
        end
    endtask

    // One clock: check ld_ready on current inputs, clock, update model, check outputs.
    task automatic cycle();
        #1;
        check("ld_ready", ld_ready, (m_mode != 2) && !stop);
        @(posedge clk);
        model_tick();
        #1;
        check("sel", sel, m_sel);
        check("sel_valid", sel_valid, m_mode != 0);
        check("busy", busy, m_mode != 0);
        check("step", step, m_step);
        check("wrap", wrap, m_wrap);
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; ld_valid = 0; ld_sel = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    logic [SW-1:0] saved_sel;
    bit            reached;

    initial begin
        m_mode = 0; m_sel = 0; m_left = 0; m_resume = 0; m_step = 0; m_wrap = 0;
        rst = 1; dwell = 8'd2;
        idle_inputs();
`ifdef SEQ_SKIP_MASK_EN
        skip_mask = '0;
`endif
        @(negedge clk);
        do_reset();
        check("rst_sel", sel, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ld_ready, 1);

        // Scan with dwell=2
        start = 1; cycle(); start = 0;
        check("t1_first", sel, 0);
        check("t1_valid", sel_valid, 1);
        repeat (14) cycle();
        check("t1_sel7", sel, 7);
        repeat (2) cycle();
        check("t1_wrap_sel", sel, 0);
        check("t1_wrap", wrap, 1);

        // dwell=0 advances every cycle
        dwell = 8'd0;
        repeat (20) cycle();

        // Load while scanning with dwell=3
        do_reset();
        dwell = 8'd3;
        start = 1; cycle(); start = 0;
        reached = 0;
        for (int i = 0; i < 50 && !reached; i++) begin
            if (sel == 2) reached = 1; else cycle();
        end
        check("t3_reach", reached, 1);
        ld_valid = 1; ld_sel = 3'd5; cycle(); ld_valid = 0;
        check("t3_loaded", sel, 5);
        repeat (3) cycle();
        check("t3_resume", sel, 6);
        check("t3_step", step, 1);
        repeat (4) cycle();

        // stop and load together while scanning
        saved_sel = sel;
        stop = 1; ld_valid = 1; ld_sel = saved_sel + 3'd3;
        cycle();
        idle_inputs();
        check("t4_busy", busy, 0);
        check("t4_sel", sel, saved_sel);
        cycle();

        // reset in the middle of a hold
        dwell = 8'd10;
        ld_valid = 1; ld_sel = 3'd4; cycle(); ld_valid = 0;
        repeat (3) cycle();
        check("t5_hold", busy, 1);
        rst = 1; cycle(); rst = 0;
        check("t5_sel", sel, 0);
        check("t5_step", step, 0);
        check("t5_ready", ld_ready, 1);

`ifdef SEQ_SKIP_MASK_EN
        skip_mask = 8'b0110_1010;
        dwell = 8'd1;
        start = 1; cycle(); start = 0;
        check("t6_s0", sel, 0);
        cycle(); check("t6_s2", sel, 2);
        cycle(); check("t6_s4", sel, 4);
        cycle(); check("t6_s7", sel, 7);
        cycle(); check("t6_s0b", sel, 0); check("t6_wrap", wrap, 1);
        skip_mask = 8'hFE;
        cycle(); check("t6_hold", sel, 0); check("t6_nostep", step, 0);
        skip_mask = '0;
        do_reset();
`endif

        // Random phase
        for (int i = 0; i < 2500; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            start    = ($urandom_range(0, 9) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            ld_valid = ($urandom_range(0, 14) == 0);
            ld_sel   = SW'($urandom_range(0, NCH - 1));
            if ($urandom_range(0, 19) == 0) dwell = DW'($urandom_range(0, 5));
`ifdef SEQ_SKIP_MASK_EN
            if ($urandom_range(0, 29) == 0) skip_mask = NCH'($urandom & $urandom);
`endif
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
